// File: rtl/syscall_pkg.sv
// Shared constants, state encoding and helpers for the syscall console.
package syscall_pkg;

    localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
    localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
    localparam logic [31:0] SYS_EXIT       = 32'd10;
    localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    localparam logic [31:0] POW10 [10] = '{
        32'd1, 32'd10, 32'd100, 32'd1000, 32'd10000,
        32'd100000, 32'd1000000, 32'd10000000,
        32'd100000000, 32'd1000000000
    };

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHAR_EMIT,
        S_STR_REQ,
        S_STR_WAIT,
        S_STR_EMIT,
        S_INT_SIGN,
        S_INT_DIGIT,
        S_INT_EMIT,
        S_HALTED
    } state_t;

    // Big-endian byte pick: offset 0 is the most significant byte.
    function automatic logic [7:0] byte_sel(input logic [31:0] w,
                                            input logic [1:0] off);
        logic [7:0] b;
        b = w[31:24];
        case (off)
            2'd1: b = w[23:16];
            2'd2: b = w[15:8];
            2'd3: b = w[7:0];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/console_char_port.sv
// Registered valid/ready output stage toward the console sink.
module console_char_port (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       char_ready,
    output logic       char_valid,
    output logic [7:0] char_data
);

    // A load in the handshake cycle replaces the accepted character.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_valid <= 1'b0;
            char_data  <= 8'h00;
        end else if (load) begin
            char_valid <= 1'b1;
            char_data  <= load_data;
        end else if (char_valid && char_ready) begin
            char_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/syscall_console.sv
// Services print int/string/char and exit syscalls from the Memory stage,
// holding the pipeline until each request has been fully streamed out.
module syscall_console
    import syscall_pkg::*;
#(
    parameter int MAX_STR = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sig_syscall,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    output logic        stall_req,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_read_data,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        sig_halt,
    output logic        sig_bad_syscall
);

    localparam int CW = $clog2(MAX_STR + 1);

    state_t        state, state_n;
    logic [31:0]   addr, addr_n;
    logic [31:0]   word, word_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]   mag, mag_n;
    logic [3:0]    k, k_n;
    logic [3:0]    digit, digit_n;
    logic          started, started_n;
    logic          halt_n, bad_n;
    logic          load;
    logic [7:0]    load_data;
    logic [7:0]    ch;
    logic          hs, free;

    assign hs       = char_valid && char_ready;
    assign free     = !char_valid || char_ready;
    assign mem_addr = {addr[31:2], 2'b00};

    console_char_port u_port (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_data  (load_data),
        .char_ready (char_ready),
        .char_valid (char_valid),
        .char_data  (char_data)
    );

    always_comb begin
        state_n   = state;
        addr_n    = addr;
        word_n    = word;
        cnt_n     = cnt;
        mag_n     = mag;
        k_n       = k;
        digit_n   = digit;
        started_n = started;
        halt_n    = sig_halt;
        bad_n     = sig_bad_syscall;
        load      = 1'b0;
        load_data = 8'h00;
        mem_rd_en = 1'b0;
        ch        = 8'h00;
        stall_req = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                if (sig_syscall) begin
                    case (v0)
                        SYS_PRINT_CHAR: begin
                            stall_req = 1'b1;
                            load      = 1'b1;
                            load_data = a0[7:0];
                            state_n   = S_CHAR_EMIT;
                        end
                        SYS_PRINT_STR: begin
                            stall_req = 1'b1;
                            addr_n    = a0;
                            cnt_n     = '0;
                            state_n   = S_STR_REQ;
                        end
                        SYS_PRINT_INT: begin
                            stall_req = 1'b1;
                            mag_n     = a0;
                            state_n   = S_INT_SIGN;
                        end
                        SYS_EXIT: begin
                            stall_req = 1'b1;
                            halt_n    = 1'b1;
                            state_n   = S_HALTED;
                        end
                        default: bad_n = 1'b1;
                    endcase
                end
            end
            S_CHAR_EMIT: begin
                if (hs) state_n = S_IDLE;
            end
            S_STR_REQ: begin
                mem_rd_en = 1'b1;
                state_n   = S_STR_WAIT;
            end
            S_STR_WAIT: begin
                word_n = mem_read_data;
                ch     = byte_sel(mem_read_data, addr[1:0]);
                if (ch == 8'h00) begin
                    state_n = S_IDLE;
                end else begin
                    load      = 1'b1;
                    load_data = ch;
                    state_n   = S_STR_EMIT;
                end
            end
            S_STR_EMIT: begin
                if (hs) begin
                    addr_n = addr + 32'd1;
                    cnt_n  = cnt + 1'b1;
                    ch     = byte_sel(word, addr_n[1:0]);
                    if (cnt_n == CW'(MAX_STR)) begin
                        state_n = S_IDLE;
                    end else if (addr_n[1:0] == 2'd0) begin
                        state_n = S_STR_REQ;
                    end else if (ch == 8'h00) begin
                        state_n = S_IDLE;
                    end else begin
                        load      = 1'b1;
                        load_data = ch;
                    end
                end
            end
            S_INT_SIGN: begin
                k_n       = 4'd9;
                digit_n   = 4'd0;
                started_n = 1'b0;
                state_n   = S_INT_DIGIT;
                // Unsigned negation keeps 0x80000000 as magnitude 2^31.
                if (mag[31]) begin
                    load      = 1'b1;
                    load_data = ASCII_MINUS;
                    mag_n     = -mag;
                end
            end
            S_INT_DIGIT: begin
                if (mag >= POW10[k]) begin
                    mag_n   = mag - POW10[k];
                    digit_n = digit + 4'd1;
                end else if (digit == 4'd0 && !started && k != 4'd0) begin
                    k_n = k - 4'd1;
                end else if (free) begin
                    load      = 1'b1;
                    load_data = ASCII_ZERO + {4'b0000, digit};
                    started_n = 1'b1;
                    state_n   = S_INT_EMIT;
                end
            end
            S_INT_EMIT: begin
                if (hs) begin
                    if (k == 4'd0) begin
                        state_n = S_IDLE;
                    end else begin
                        k_n     = k - 4'd1;
                        digit_n = 4'd0;
                        state_n = S_INT_DIGIT;
                    end
                end
            end
            S_HALTED: stall_req = 1'b1;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            addr            <= '0;
            word            <= '0;
            cnt             <= '0;
            mag             <= '0;
            k               <= '0;
            digit           <= '0;
            started         <= 1'b0;
            sig_halt        <= 1'b0;
            sig_bad_syscall <= 1'b0;
        end else begin
            state           <= state_n;
            addr            <= addr_n;
            word            <= word_n;
            cnt             <= cnt_n;
            mag             <= mag_n;
            k               <= k_n;
            digit           <= digit_n;
            started         <= started_n;
            sig_halt        <= halt_n;
            sig_bad_syscall <= bad_n;
        end
    end

endmodule
